// File: rtl/lcd_spi_tx_if.sv
// lcd_spi_tx_if: valid/ready write port carrying {dc, byte} entries.
// The master pushes; the streamer accepts while its FIFO has room.
interface lcd_spi_tx_if;
  logic [8:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: FIFO-fed SPI mode-0 byte streamer for the Eye-SPI TFT pins.
// Optional rectangle-fill engine is built when LCD_TX_FILL_EN is defined.
module lcd_spi_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  lcd_spi_tx_if.slave                 s,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef LCD_TX_FILL_EN
  input  logic [15:0]                 fill_color,
  input  logic [15:0]                 fill_count,
  input  logic                        fill_start,
`endif
  output logic                        sclk,
  output logic                        mosi,
  output logic                        cs_n,
  output logic                        dc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, empty;
  logic          push, pop;

  logic [7:0]    sh;
  logic [2:0]    bit_cnt;
  logic [7:0]    div_cnt;
  logic          tick, take;
  logic          have_next, fill_src;
  logic [8:0]    nxt;

  assign full       = (cnt == FULL_LVL);
  assign empty      = (cnt == '0);
  assign push       = s.valid && !full;
  assign s.ready    = !full;
  assign fifo_level = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= s.data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LCD_TX_FILL_EN
  logic [15:0] f_color;
  logic [15:0] f_rem;
  logic        f_hi;
  logic        f_go;

  // A fill only launches from a fully quiet block so queued writes
  // never get reordered behind the pixels.
  assign f_go = (state == IDLE) && empty && (f_rem == '0)
             && fill_start && (fill_count != '0);
  assign fill_src = (f_rem != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_color <= '0;
      f_rem   <= '0;
      f_hi    <= 1'b1;
    end else if (f_go) begin
      f_color <= fill_color;
      f_rem   <= fill_count;
      f_hi    <= 1'b1;
    end else if (take && fill_src) begin
      f_hi <= !f_hi;
      if (!f_hi) f_rem <= f_rem - 16'd1;
    end
  end

  always_comb begin
    have_next = fill_src || !empty;
    nxt       = mem[rp];
    if (fill_src)
      nxt = {1'b1, f_hi ? f_color[15:8] : f_color[7:0]};
  end

  assign busy = !empty || (state != IDLE) || fill_src;
`else
  assign fill_src  = 1'b0;
  assign have_next = !empty;
  assign nxt       = mem[rp];
  assign busy      = !empty || (state != IDLE);
`endif

  assign pop  = take && !fill_src;
  assign tick = (div_cnt == DIV_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (have_next) begin
          take    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick && sclk && bit_cnt == 3'd7) begin
          if (have_next) take = 1'b1;
          else           state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load restarts the bit clock low, so dc/mosi of the next byte
  // always change while sclk is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      dc      <= 1'b0;
    end else if (take) begin
      sh      <= nxt[7:0];
      mosi    <= nxt[7];
      dc      <= nxt[8];
      cs_n    <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= !sclk;
            if (sclk) begin
              bit_cnt <= bit_cnt + 3'd1;
              sh      <= {sh[6:0], 1'b0};
              mosi    <= sh[6];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (tick) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
